// File: rtl/blink_pkg.sv
// Shared definitions for the key-driven blink controller and the downstream LED blinker.
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kb_state_t;

  localparam logic [31:0] HALF_P_0 = 32'd49_999_999;
  localparam logic [31:0] HALF_P_1 = 32'd24_999_999;
  localparam logic [31:0] HALF_P_2 = 32'd12_499_999;
  localparam logic [31:0] HALF_P_3 = 32'd4_999_999;

  function automatic logic [31:0] half_period_of(mode_t m);
    case (m)
      MODE_0:  return HALF_P_0;
      MODE_1:  return HALF_P_1;
      MODE_2:  return HALF_P_2;
      default: return HALF_P_3;
    endcase
  endfunction

  function automatic mode_t mode_inc(mode_t m);
    logic [1:0] raw;
    raw = m + 2'd1;
    return mode_t'(raw);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer and debounce FSM producing one strobe per qualified press.
//   state           | meaning
//   ST_IDLE         | key released and qualified
//   ST_PRESS_WAIT   | key low, counting stable low cycles
//   ST_HELD         | press qualified and reported, waiting for release
//   ST_RELEASE_WAIT | key high, counting stable high cycles
module key_debounce
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_evt,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  // The cycle that leaves IDLE/HELD is already the first stable sample, so the
  // terminal count sits one below DEBOUNCE_CYC-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_low;
  kb_state_t              state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(key_n);
    end
  end

  assign key_low = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      press_pulse <= press_evt;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_low) begin
          state_n = ST_PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_low) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = ST_HELD;
          cnt_n     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!key_low) begin
          state_n = ST_RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_low) begin
          state_n = ST_HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_blink_ctrl.sv
// Key-press blink mode selector: debounced presses step the mode and reload the blink half-period.
module key_blink_ctrl
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  output logic        press_pulse,
  output logic [1:0]  mode,
  output logic [31:0] half_period,
  output logic        period_upd
);

  logic  press_evt;
  mode_t mode_q;
  mode_t mode_nxt;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .press_evt   (press_evt),
    .press_pulse (press_pulse)
  );

  assign mode_nxt = mode_inc(mode_q);

  // Registered from the same event as press_pulse so all outputs move on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_0;
      half_period <= HALF_P_0;
      period_upd  <= 1'b0;
    end else begin
      period_upd <= press_evt;
      if (press_evt) begin
        mode_q      <= mode_nxt;
        half_period <= half_period_of(mode_nxt);
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_key_blink_ctrl.sv
// Scoreboard bench for key_blink_ctrl with a short debounce window.
module tb_key_blink_ctrl;

  localparam int DEB  = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic        press_pulse;
  logic [1:0]  mode;
  logic [31:0] half_period;
  logic        period_upd;

  key_blink_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .press_pulse (press_pulse),
    .mode        (mode),
    .half_period (half_period),
    .period_upd  (period_upd)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  mode;
    logic [31:0] half;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          npulse = 0;
  logic        prev_pulse = 1'b0;
  logic [1:0]  model_mode = 2'd0;
  logic [31:0] hp_tab [4] = '{32'd49_999_999, 32'd24_999_999, 32'd12_499_999, 32'd4_999_999};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (press_pulse) begin
      npulse++;
      check("pulse_gap", {31'd0, prev_pulse}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_press", {31'd0, press_pulse}, 32'd0);
      end else begin
        e = q.pop_front();
        check("press_cycle", cyc, e.cyc);
        check("press_mode", {30'd0, mode}, {30'd0, e.mode});
        check("press_half", half_period, e.half);
        check("press_upd", {31'd0, period_upd}, 32'd1);
      end
    end else if (period_upd) begin
      check("stray_upd", {31'd0, period_upd}, 32'd0);
    end
    prev_pulse = press_pulse;
  end

  task automatic expect_press();
    exp_t e;
    model_mode = model_mode + 2'd1;
    e.cyc  = cyc + LAT;
    e.mode = model_mode;
    e.half = hp_tab[model_mode];
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_mode = 2'd0;
    @(posedge clk);
    #1;
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_half", half_period, 32'd49_999_999);
    check("rst_pulse", {31'd0, press_pulse}, 32'd0);
    check("rst_upd", {31'd0, period_upd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_key(input int low_cyc, input bit expected);
    @(negedge clk);
    key_n = 1'b0;
    if (expected) expect_press();
    repeat (low_cyc) @(negedge clk);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check(name, q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    int n0;
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    // Idle after reset
    n0 = npulse;
    repeat (100) @(negedge clk);
    check("idle_strobes", npulse - n0, 32'd0);
    check("idle_mode", {30'd0, mode}, 32'd0);
    check("idle_half", half_period, 32'd49_999_999);

    // Single clean press held 20 cycles
    press_key(20, 1'b1);
    drain("single_press_seen");
    check("single_mode", {30'd0, mode}, 32'd1);
    check("single_half", half_period, 32'd24_999_999);

    // Bounce: low 5, high 3, low 5
    n0 = npulse;
    @(negedge clk); key_n = 1'b0;
    repeat (5) @(negedge clk); key_n = 1'b1;
    repeat (3) @(negedge clk); key_n = 1'b0;
    repeat (5) @(negedge clk); key_n = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_strobes", npulse - n0, 32'd0);
    check("bounce_mode", {30'd0, mode}, 32'd1);

    // Four presses from reset wrap the mode back to 0
    do_reset();
    for (int k = 0; k < 4; k++) press_key(12, 1'b1);
    drain("four_press_seen");
    check("wrap_mode", {30'd0, mode}, 32'd0);
    check("wrap_half", half_period, 32'd49_999_999);

    // Long hold with short high glitches: one press only
    n0 = npulse;
    @(negedge clk);
    key_n = 1'b0;
    expect_press();
    for (int i = 0; i < 1000; i++) begin
      key_n = (i >= 100 && (i % 100) < 3) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    drain("hold_press_seen");
    check("hold_strobes", npulse - n0, 32'd1);
    check("hold_mode", {30'd0, mode}, 32'd1);

    // Reset in the middle of a press, key still low
    do_reset();
    @(negedge clk);
    key_n = 1'b0;
    repeat (7) @(negedge clk);
    n0 = npulse;
    rst = 1'b1;
    model_mode = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_strobes", npulse - n0, 32'd0);
    expect_press();
    repeat (25) @(negedge clk);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    drain("post_rst_press_seen");
    check("post_rst_mode", {30'd0, mode}, 32'd1);
    check("post_rst_half", half_period, 32'd24_999_999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
